mips: RTL and testbench

- Single-cycle MIPS-subset CPU with a minimal CP0 for external-interrupt handling.
- Instruction and data memories are external and read combinationally.
- Stores to the interrupt-generator acknowledge window go out on a separate port.
- Trace ports expose the GRF write and the PC of the retiring instruction for bench logging.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mips_cp0.sv | 61 ++++++
 rtl/mips.sv | 191 +++++++++++++++++++
 tb/tb_mips.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings, CP0 constants and address-map defaults for the mips core.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] INT_ACK_ADDR_DEF = 32'h0000_7F20;
  localparam logic [31:0] DM_LIMIT_DEF     = 32'h0000_3000;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d, OP_LUI  = 6'h0f, OP_COP0 = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LW   = 6'h23, OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29, OP_SW   = 6'h2b;

  localparam logic [5:0] F_JR  = 6'h08, F_ERET = 6'h18, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR   = 6'h25, F_SLT  = 6'h2a;

  localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;

  localparam logic [4:0] CP0_SR = 5'd12, CP0_CAUSE = 5'd13, CP0_EPC = 5'd14;
  localparam int unsigned SR_IE = 0, SR_EXL = 1, SR_IM_HW2 = 12;
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_RI = 5'd10;

  typedef enum logic [1:0] {MEM_NONE, MEM_WORD, MEM_HALF, MEM_BYTE} mem_size_e;

  function automatic logic [3:0] byte_lanes(input mem_size_e sz, input logic [1:0] a);
    case (sz)
      MEM_WORD: return 4'b1111;
      MEM_HALF: return a[1] ? 4'b1100 : 4'b0011;
      MEM_BYTE: return 4'b0001 << a;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic insn_known(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [5:0] funct);
    case (op)
      OP_SPECIAL: return funct inside {F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_JR};
      OP_COP0:    return (rs == RS_MF) || (rs == RS_MT) || (rs == RS_CO && funct == F_ERET);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LUI,
      OP_LB, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_cp0.sv
// Minimal coprocessor 0: SR/Cause/EPC, interrupt decision, EXL/EPC bookkeeping.
module mips_cp0
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic [31:0] pc,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        mtc0_en,
  input  logic        eret_en,
  input  logic [4:0]  reg_idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_req,
  output logic        exc_take
);

  logic [31:0] sr;
  logic        ip_hw2;
  logic [4:0]  exc_code_q;
  logic        exl;

  assign exl      = sr[SR_EXL];
  // Uses the registered SR, so an mtc0 to SR only matters from the next cycle.
  assign int_req  = sr[SR_IE] & ~exl & sr[SR_IM_HW2] & interrupt;
  assign exc_take = exc_req & ~exl & ~int_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr         <= '0;
      epc        <= '0;
      ip_hw2     <= 1'b0;
      exc_code_q <= '0;
    end else begin
      ip_hw2 <= interrupt;
      if (int_req || exc_take) begin
        epc         <= pc;
        exc_code_q  <= int_req ? EXC_INT : exc_code;
        sr[SR_EXL]  <= 1'b1;
      end else if (eret_en) begin
        sr[SR_EXL]  <= 1'b0;
      end else if (mtc0_en) begin
        if (reg_idx == CP0_SR)       sr  <= wdata & SR_WMASK;
        else if (reg_idx == CP0_EPC) epc <= {wdata[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    case (reg_idx)
      CP0_SR:    rdata = sr;
      CP0_CAUSE: rdata = {16'b0, 3'b0, ip_hw2, 5'b0, exc_code_q, 2'b00};
      CP0_EPC:   rdata = epc;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/mips.sv
// Single-cycle MIPS-subset core with external-interrupt CP0.
// Define MIPS_SYNC_EXC_EN to enable RI/AdEL/AdES synchronous exceptions.
module mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
  parameter logic [31:0] INT_ACK_ADDR = INT_ACK_ADDR_DEF,
  parameter logic [31:0] DM_LIMIT     = DM_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] macroscopic_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  logic [31:0] pc, pc_plus4, pc_next, seq_next, epc, cp0_rdata;
  logic [31:0] grf [0:31];
  logic [31:0] rs_v, rt_v;
  logic signed [31:0] rs_s, rt_s, simm;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, exc_code;
  logic [15:0] imm;
  logic [7:0]  ld_byte;
  logic        wr_en, is_store, is_mtc0, is_eret, exc_req, int_req, exc_take, suppress;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  mem_size_e   sz;
  logic [3:0]  lanes;
  logic        commit, in_dm, in_ack;

  assign op       = i_inst_rdata[31:26];
  assign rs       = i_inst_rdata[25:21];
  assign rt       = i_inst_rdata[20:16];
  assign rd       = i_inst_rdata[15:11];
  assign funct    = i_inst_rdata[5:0];
  assign imm      = i_inst_rdata[15:0];
  assign simm     = {{16{imm[15]}}, imm};
  assign rs_v     = grf[rs];
  assign rt_v     = grf[rt];
  assign rs_s     = rs_v;
  assign rt_s     = rt_v;
  assign pc_plus4 = pc + 32'd4;

  assign m_data_addr = rs_s + simm;

  always_comb begin
    case (m_data_addr[1:0])
      2'd0:    ld_byte = m_data_rdata[7:0];
      2'd1:    ld_byte = m_data_rdata[15:8];
      2'd2:    ld_byte = m_data_rdata[23:16];
      default: ld_byte = m_data_rdata[31:24];
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = rd;
    wr_data  = '0;
    is_store = 1'b0;
    is_mtc0  = 1'b0;
    is_eret  = 1'b0;
    sz       = MEM_NONE;
    seq_next = pc_plus4;
    case (op)
      OP_SPECIAL: begin
        wr_en = funct inside {F_ADDU, F_SUBU, F_AND, F_OR, F_SLT};
        case (funct)
          F_ADDU:  wr_data = rs_v + rt_v;
          F_SUBU:  wr_data = rs_v - rt_v;
          F_AND:   wr_data = rs_v & rt_v;
          F_OR:    wr_data = rs_v | rt_v;
          F_SLT:   wr_data = {31'b0, rs_s < rt_s};
          F_JR:    seq_next = rs_v;
          default: wr_data = '0;
        endcase
      end
      OP_ORI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_v | {16'b0, imm}; end
      OP_ADDIU: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_s + simm; end
      OP_LUI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = {imm, 16'b0}; end
      OP_LW:    begin wr_en = 1'b1; wr_addr = rt; wr_data = m_data_rdata; sz = MEM_WORD; end
      OP_LB:    begin
        wr_en = 1'b1; wr_addr = rt; wr_data = {{24{ld_byte[7]}}, ld_byte}; sz = MEM_BYTE;
      end
      OP_SW:    begin is_store = 1'b1; sz = MEM_WORD; end
      OP_SH:    begin is_store = 1'b1; sz = MEM_HALF; end
      OP_SB:    begin is_store = 1'b1; sz = MEM_BYTE; end
      OP_BEQ:   if (rs_v == rt_v) seq_next = pc_plus4 + {simm[29:0], 2'b00};
      OP_BNE:   if (rs_v != rt_v) seq_next = pc_plus4 + {simm[29:0], 2'b00};
      OP_J:     seq_next = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};
      OP_JAL:   begin
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = pc_plus4;
        seq_next = {pc_plus4[31:28], i_inst_rdata[25:0], 2'b00};
      end
      OP_COP0:  begin
        if (rs == RS_MF) begin wr_en = 1'b1; wr_addr = rt; wr_data = cp0_rdata; end
        is_mtc0 = (rs == RS_MT);
        is_eret = (rs == RS_CO) && (funct == F_ERET);
      end
      default:  wr_en = 1'b0;
    endcase
  end

  assign in_ack = (m_data_addr[31:2] == INT_ACK_ADDR[31:2]);
  assign in_dm  = (m_data_addr < DM_LIMIT) && !in_ack;

`ifdef MIPS_SYNC_EXC_EN
  logic misalign;
  assign misalign = ((sz == MEM_WORD) && (m_data_addr[1:0] != 2'b00)) ||
                    ((sz == MEM_HALF) && m_data_addr[0]);
  always_comb begin
    exc_req  = 1'b0;
    exc_code = EXC_INT;
    if (!insn_known(op, rs, funct)) begin
      exc_req = 1'b1; exc_code = EXC_RI;
    end else if (sz != MEM_NONE && (misalign || !(in_dm || in_ack))) begin
      exc_req = 1'b1; exc_code = is_store ? EXC_ADES : EXC_ADEL;
    end
  end
`else
  assign exc_req  = 1'b0;
  assign exc_code = EXC_INT;
`endif

  assign suppress = int_req | exc_req;
  assign commit   = reset & ~suppress;
  assign lanes    = is_store ? byte_lanes(sz, m_data_addr[1:0]) : 4'b0000;

  assign m_data_byteen = (commit && in_dm)  ? lanes : 4'b0000;
  assign m_int_byteen  = (commit && in_ack) ? lanes : 4'b0000;
  assign m_int_addr    = m_data_addr;
  assign m_data_wdata  = (sz == MEM_HALF) ? {2{rt_v[15:0]}} :
                         (sz == MEM_BYTE) ? {4{rt_v[7:0]}}  : rt_v;

  assign w_grf_we       = commit & wr_en;
  assign w_grf_addr     = wr_addr;
  assign w_grf_wdata    = wr_data;
  assign macroscopic_pc = pc;
  assign i_inst_addr    = pc;
  assign m_inst_addr    = pc;
  assign w_inst_addr    = pc;

  mips_cp0 u_cp0 (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .pc        (pc),
    .exc_req   (exc_req),
    .exc_code  (exc_code),
    .mtc0_en   (is_mtc0 & ~exc_req),
    .eret_en   (is_eret & ~exc_req),
    .reg_idx   (rd),
    .wdata     (rt_v),
    .rdata     (cp0_rdata),
    .epc       (epc),
    .int_req   (int_req),
    .exc_take  (exc_take)
  );

  // A suppressed instruction ignored under EXL still falls through sequentially.
  always_comb begin
    if (int_req || exc_take) pc_next = HANDLER_PC;
    else if (exc_req)        pc_next = pc_plus4;
    else if (is_eret)        pc_next = epc;
    else                     pc_next = seq_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) grf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (w_grf_we && w_grf_addr != 5'd0) grf[w_grf_addr] <= w_grf_wdata;
    end
  end

endmodule

// File: tb/tb_mips.sv
// Directed program bench for mips: small instruction ROM and data RAM model.
module tb_mips;

  logic        clk = 1'b0;
  logic        reset, interrupt;
  logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata, m_data_addr, m_data_rdata;
  logic [31:0] m_data_wdata, m_int_addr, m_inst_addr, w_grf_wdata, w_inst_addr;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;

  logic [31:0] imem [0:2047];
  logic [31:0] dmem [0:15];
  logic [31:0] pc_off;
  int          total = 0, passed = 0;

  always #5 clk = ~clk;

  mips dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .m_inst_addr(m_inst_addr), .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
  );

  assign pc_off       = (i_inst_addr - 32'h0000_3000) >> 2;
  assign i_inst_rdata = (pc_off < 32'd2048) ? imem[pc_off[10:0]] : 32'h0;
  assign m_data_rdata = (m_data_addr < 32'd64) ? dmem[m_data_addr[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (m_data_addr < 32'd64) begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b]) dmem[m_data_addr[5:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input logic [5:0] f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] o, input int s, input int t,
                                        input logic [15:0] im);
    return {o, 5'(s), 5'(t), im};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] o, input logic [31:0] a);
    return {o, a[27:2]};
  endfunction
  function automatic logic [31:0] enc_c0(input logic [4:0] sel, input int t, input int d);
    return {6'h10, sel, 5'(t), 5'(d), 11'h000};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    imem[(a - 32'h0000_3000) >> 2] = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    interrupt = 1'b0;
    for (int i = 0; i < 2048; i++) imem[i] = 32'h0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;

    put(32'h3000, enc_i(6'h0d, 0, 1, 16'h1234));   // ori $1,$0,0x1234
    put(32'h3004, enc_i(6'h2b, 0, 1, 16'h0004));   // sw $1,4($0)
    put(32'h3008, enc_i(6'h0d, 0, 2, 16'h00AB));   // ori $2,$0,0xAB
    put(32'h300C, enc_i(6'h28, 0, 2, 16'h0006));   // sb $2,6($0)
    put(32'h3010, enc_j(6'h03, 32'h3030));         // jal 0x3030
    put(32'h3014, enc_i(6'h20, 0, 3, 16'h0006));   // lb $3,6($0)
    put(32'h3018, enc_i(6'h09, 4, 4, 16'h0001));   // addiu $4,$4,1
    put(32'h301C, enc_i(6'h04, 4, 8, 16'hFFFE));   // beq $4,$8,-2
    put(32'h3020, enc_r(4, 8, 10, 6'h21));         // addu $10,$4,$8
    put(32'h3024, enc_r(8, 4, 14, 6'h23));         // subu $14,$8,$4
    put(32'h3028, enc_r(14, 8, 15, 6'h2a));        // slt $15,$14,$8
    put(32'h302C, enc_j(6'h02, 32'h3040));         // j 0x3040
    put(32'h3030, enc_i(6'h0d, 0, 8, 16'h0001));   // ori $8,$0,1
    put(32'h3034, enc_i(6'h0d, 0, 9, 16'h1001));   // ori $9,$0,0x1001
    put(32'h3038, enc_c0(5'h04, 9, 12));           // mtc0 $9,SR
    put(32'h303C, enc_r(31, 0, 0, 6'h08));         // jr $31
    put(32'h3040, enc_i(6'h0f, 0, 16, 16'hABCD));  // lui $16,0xABCD
    put(32'h3044, enc_i(6'h23, 0, 17, 16'h0004));  // lw $17,4($0)
    put(32'h3048, enc_i(6'h29, 0, 2, 16'h0002));   // sh $2,2($0)
    put(32'h304C, enc_i(6'h2b, 0, 1, 16'h5000));   // sw $1,0x5000($0)
    put(32'h3050, enc_c0(5'h00, 18, 12));          // mfc0 $18,SR
    put(32'h3054, enc_j(6'h02, 32'h3054));         // j .
    put(32'h4180, enc_c0(5'h00, 11, 13));          // mfc0 $11,Cause
    put(32'h4184, enc_c0(5'h00, 12, 14));          // mfc0 $12,EPC
    put(32'h4188, enc_i(6'h28, 0, 2, 16'h7F20));   // sb $2,0x7F20($0)
    put(32'h418C, 32'h4200_0018);                  // eret

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", macroscopic_pc, 32'h0000_3000);
    chk("reset_we", {31'b0, w_grf_we}, 32'h0);
    chk("reset_byteen", {24'b0, m_data_byteen, m_int_byteen}, 32'h0);

    @(negedge clk) reset = 1'b1;
    #1;
    chk("ori_we", {31'b0, w_grf_we}, 32'h1);
    chk("ori_addr", {27'b0, w_grf_addr}, 32'd1);
    chk("ori_data", w_grf_wdata, 32'h0000_1234);
    chk("ori_inst", w_inst_addr, 32'h0000_3000);

    step();
    chk("sw_byteen", {28'b0, m_data_byteen}, 32'hF);
    chk("sw_addr", m_data_addr, 32'h0000_0004);
    chk("sw_wdata", m_data_wdata, 32'h0000_1234);
    step();
    step();
    chk("sb_byteen", {28'b0, m_data_byteen}, 32'h4);
    chk("sb_addr", m_data_addr, 32'h0000_0006);
    chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
    step();
    chk("jal_addr", {27'b0, w_grf_addr}, 32'd31);
    chk("jal_data", w_grf_wdata, 32'h0000_3014);
    step();
    chk("jal_target", macroscopic_pc, 32'h0000_3030);
    step();
    step();
    chk("mtc0_no_grf", {31'b0, w_grf_we}, 32'h0);
    step();
    step();
    chk("jr_return", macroscopic_pc, 32'h0000_3014);
    chk("lb_data", w_grf_wdata, 32'hFFFF_FFAB);
    step();
    chk("addiu_data", w_grf_wdata, 32'h0000_0001);
    step();
    chk("beq_no_grf", {31'b0, w_grf_we}, 32'h0);
    step();
    chk("beq_back", macroscopic_pc, 32'h0000_3018);
    step();
    step();
    chk("loop_exit", macroscopic_pc, 32'h0000_3020);

    interrupt = 1'b1;
    #1;
    chk("irq_no_grf", {31'b0, w_grf_we}, 32'h0);
    chk("irq_no_store", {24'b0, m_data_byteen, m_int_byteen}, 32'h0);
    step();
    chk("irq_vector", macroscopic_pc, 32'h0000_4180);
    chk("cause_ip", w_grf_wdata, 32'h0000_1000);
    step();
    chk("epc", w_grf_wdata, 32'h0000_3020);
    step();
    chk("ack_int_byteen", {28'b0, m_int_byteen}, 32'h1);
    chk("ack_data_byteen", {28'b0, m_data_byteen}, 32'h0);
    chk("ack_addr", m_int_addr, 32'h0000_7F20);
    interrupt = 1'b0;
    step();
    chk("eret_no_grf", {31'b0, w_grf_we}, 32'h0);
    step();
    chk("eret_pc", macroscopic_pc, 32'h0000_3020);
    chk("addu_data", w_grf_wdata, 32'h0000_0003);
    chk("addu_addr", {27'b0, w_grf_addr}, 32'd10);
    step();
    chk("subu_data", w_grf_wdata, 32'hFFFF_FFFF);
    step();
    chk("slt_data", w_grf_wdata, 32'h0000_0001);
    step();
    step();
    chk("j_target", macroscopic_pc, 32'h0000_3040);
    chk("lui_data", w_grf_wdata, 32'hABCD_0000);
    step();
    chk("lw_data", w_grf_wdata, 32'h00AB_1234);
    step();
    chk("sh_byteen", {28'b0, m_data_byteen}, 32'hC);
    chk("sh_wdata", m_data_wdata, 32'h00AB_00AB);
    step();
    chk("unmapped_byteen", {24'b0, m_data_byteen, m_int_byteen}, 32'h0);
    step();
    chk("sr_after_eret", w_grf_wdata, 32'h0000_1001);
    step();
    chk("spin_pc", macroscopic_pc, 32'h0000_3054);

    #2 reset = 1'b0;
    #1;
    chk("async_reset_pc", macroscopic_pc, 32'h0000_3000);
    chk("async_reset_we", {31'b0, w_grf_we}, 32'h0);
    chk("async_reset_byteen", {24'b0, m_data_byteen, m_int_byteen}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
